// File: rtl/if_prefetch_unit_pkg.sv
// if_prefetch_unit_pkg: shared types and constants for the instruction prefetch unit.
package if_prefetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fifo.sv
// if_fifo: DEPTH-entry {pc,instr} buffer with synchronous flush that overrides push and pop.
module if_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: fetch FSM issuing one outstanding word fetch at a time into a small
// instruction FIFO, with redirect flushing buffered and in-flight words.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int CW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [CW-1:0]   fifo_count
);
  fetch_state_e state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic push, pop;
  logic [CW-1:0] count_next;
  fetch_entry_t din, head;
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign instr_valid = fifo_count != '0;
  assign pop = instr_valid & instr_ready & ~redirect;
  // Words returning in DRAIN, or alongside a redirect, belong to the abandoned stream.
  assign push = imem_ack & (state == BUSY) & ~redirect;
  assign count_next = fifo_count + CW'(push) - CW'(pop);
  assign imem_req = state != IDLE;
  assign din = '{pc: imem_addr, instr: imem_rdata};
  assign instr = head.instr;
  assign instr_pc = head.pc;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (!redirect && int'(count_next) < DEPTH) ? BUSY : IDLE;
      BUSY:    state_next = imem_ack ? IDLE : redirect ? DRAIN : BUSY;
      DRAIN:   state_next = imem_ack ? IDLE : DRAIN;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      imem_addr <= (state == IDLE && state_next == BUSY) ? fetch_pc : imem_addr;
      fetch_pc  <= redirect ? {redirect_pc[XLEN-1:2], 2'b00} : push ? fetch_pc + 32'd4 : fetch_pc;
    end
  end
  if_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: randomized and directed checks against a stream-level fetch model.
module tb_if_prefetch_unit;
  localparam int DEPTH = 4;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req, imem_ack, instr_valid, instr_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  logic [CW-1:0] fifo_count;
  always #5 clk = ~clk;
  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fifo_count(fifo_count)
  );
  // Model: q holds PCs of the current stream not yet consumed; mfetch is the next stream PC to fetch.
  logic [31:0] q[$];
  logic [31:0] seen[$];
  logic [31:0] mfetch, held_addr;
  logic stale, prev_req, exp_req, armed, stray, stray_rand;
  int wait_cnt, lat_min, lat_max;
  int checks = 0;
  int errors = 0;
  function automatic logic [31:0] word(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0013;
  endfunction
  task automatic reset_model();
    q.delete();
    mfetch = 32'h0;
    stale = 1'b0;
    prev_req = 1'b0;
    exp_req = 1'b0;
    armed = 1'b0;
    wait_cnt = 0;
    held_addr = 32'h0;
  endtask
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic ack;
    logic pop;
    checks++;
    if (fifo_count !== CW'(q.size())) begin
      errors++;
      $display("FAIL fifo_count: got %0d want %0d", fifo_count, q.size());
    end
    checks++;
    if (instr_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL instr_valid: got %b want %b", instr_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if (instr_pc !== q[0] || instr !== word(q[0])) begin
        errors++;
        $display("FAIL head: got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, q[0], word(q[0]));
      end
    end
    checks++;
    if (imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req: got %b want %b", imem_req, exp_req);
    end
    if (imem_req && !prev_req) begin
      checks++;
      if (imem_addr !== mfetch || q.size() >= DEPTH) begin
        errors++;
        $display("FAIL req_addr: got %h want %h (occupancy %0d)", imem_addr, mfetch, q.size());
      end
    end
    if (imem_req && prev_req) begin
      checks++;
      if (imem_addr !== held_addr) begin
        errors++;
        $display("FAIL addr_hold: got %h want %h", imem_addr, held_addr);
      end
    end
    held_addr = imem_addr;
    ack = 1'b0;
    if (imem_req) begin
      if (!armed) begin
        armed = 1'b1;
        wait_cnt = $urandom_range(lat_max, lat_min) - 1;
      end
      if (wait_cnt == 0) begin
        ack = 1'b1;
        armed = 1'b0;
      end else wait_cnt--;
    end else if (stray || (stray_rand && $urandom_range(9) == 0)) ack = 1'b1;
    if (instr_valid && rdy && !rd) seen.push_back(instr_pc);
    pop = (q.size() != 0) && rdy && !rd;
    if (rd) begin
      q.delete();
      mfetch = {rpc[31:2], 2'b00};
      stale = imem_req && !ack;
    end else begin
      if (pop) void'(q.pop_front());
      if (imem_req && ack) begin
        if (!stale) begin
          q.push_back(mfetch);
          mfetch = mfetch + 32'd4;
        end
        stale = 1'b0;
      end
    end
    exp_req = imem_req ? !ack : (!rd && q.size() < DEPTH);
    prev_req = imem_req;
    instr_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    imem_ack = ack;
    imem_rdata = (ack && imem_req) ? word(imem_addr) : $urandom;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL reset_values: got req=%b addr=%h valid=%b count=%0d want 0/0/0/0",
               imem_req, imem_addr, instr_valid, fifo_count);
    end
    rst_n = 1'b1;
    reset_model();
  endtask
  task automatic test_flow();
    seen.delete();
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 32'h0);
    checks++;
    if (seen.size() < 4) begin
      errors++;
      $display("FAIL flow_count: got %0d want >=4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== 32'(i * 4)) begin
          errors++;
          $display("FAIL flow_pc%0d: got %h want %h", i, seen[i], 32'(i * 4));
        end
      end
    end
  endtask
  task automatic test_backpressure();
    reset_dut();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'h0);
    checks++;
    if (fifo_count !== 3'd4 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL full_stall: got count=%0d req=%b want 4/0", fifo_count, imem_req);
    end
    step(1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL refill_req: got req=%b addr=%h want 1/00000010", imem_req, imem_addr);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
  endtask
  task automatic test_redirect_busy();
    int n;
    reset_dut();
    lat_min = 4;
    lat_max = 4;
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 60) begin
      step(1'b1, 1'b0, 32'h0);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL wait_fetch8: got timeout want request at 00000008");
    end
    seen.delete();
    step(1'b1, 1'b1, 32'h0000_0103);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_valid: got %b want 0", instr_valid);
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 32'h0);
    checks++;
    if (seen.size() == 0 || seen[0] !== 32'h100) begin
      errors++;
      $display("FAIL redirect_first: got %h want 00000100", seen.size() ? seen[0] : 32'hx);
    end
  endtask
  task automatic test_redirect_ack_pop();
    int n;
    reset_dut();
    lat_min = 1;
    lat_max = 1;
    n = 0;
    while (!(fifo_count == 3'd2 && imem_req) && n < 60) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL wait_two: got timeout want 2 entries with request");
    end
    step(1'b1, 1'b1, 32'h0000_0200);
    checks++;
    if (fifo_count !== '0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack_pop: got count=%0d valid=%b want 0/0", fifo_count, instr_valid);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL target_req: got req=%b addr=%h want 1/00000200", imem_req, imem_addr);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
  endtask
  task automatic test_wrap();
    lat_min = 1;
    lat_max = 3;
    seen.delete();
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 32'h0);
    checks++;
    if (seen.size() < 2 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: got %h,%h want fffffffc,00000000",
               seen.size() > 0 ? seen[0] : 32'hx, seen.size() > 1 ? seen[1] : 32'hx);
    end
  endtask
  task automatic test_async_reset();
    int n;
    reset_dut();
    lat_min = 3;
    lat_max = 3;
    n = 0;
    while (!(fifo_count != '0 && imem_req) && n < 60) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL wait_busy: got timeout want busy with entries");
    end
    #2 rst_n = 1'b0;
    imem_ack = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || fifo_count !== '0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got req=%b count=%0d valid=%b want 0/0/0", imem_req, fifo_count, instr_valid);
    end
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    stray = 1'b0;
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL stray_ack: got count=%0d want 0", fifo_count);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
  endtask
  task automatic test_random();
    reset_dut();
    lat_min = 1;
    lat_max = 4;
    stray_rand = 1'b1;
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(3) != 0), 1'($urandom_range(19) == 0), $urandom);
    stray_rand = 1'b0;
  endtask
  initial begin
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    stray = 1'b0;
    stray_rand = 1'b0;
    lat_min = 1;
    lat_max = 1;
    reset_model();
    test_reset();
    test_flow();
    test_backpressure();
    test_redirect_busy();
    test_redirect_ack_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
